// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    REQ_CPU,
    REQ_DBG
  } requester_e;

  // Wait counter width; large enough to hold MEM_LAT_MAX.
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// slave: the arbiter's view. master: the environment's view (CPU, debug, memory).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way pick: a lone requester wins; on a tie the one that
// was not served last wins, unless prio_b forces b.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  requester_e last,
  input  logic       prio_b,
  output requester_e winner,
  output logic       any
);

  // Select the winner among the active requesters.
  always_comb begin
    any    = req_a | req_b;
    winner = REQ_CPU;
    if (req_a && req_b) begin
      winner = (prio_b || last == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (req_b) begin
      winner = REQ_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the CPU and a debug/loader port.
// Optional macro DBG_PRIORITY_EN: debug wins every tie instead of round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..4");
  end

`ifdef DBG_PRIORITY_EN
  localparam logic PRIO_DBG = 1'b1;
`else
  localparam logic PRIO_DBG = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

  arb_state_e        state_q, state_d;
  requester_e        owner_q, owner_d;
  requester_e        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  requester_e        winner;
  logic              any_req;
  logic              ack;
  logic              cpu_ack, dbg_ack;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;

  mem_port_arbiter_rr_pick2 u_pick (
    .req_a  (bus.cpu_req),
    .req_b  (bus.dbg_req),
    .last   (last_q),
    .prio_b (PRIO_DBG),
    .winner (winner),
    .any    (any_req)
  );

  // State and latched access registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_CPU;
      last_q      <= REQ_DBG;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state: grant in IDLE, strobe in ISSUE, count latency in WAIT.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          last_d  = winner;
          if (winner == REQ_DBG) begin
            mem_we_d    = bus.dbg_we;
            mem_addr_d  = bus.dbg_addr;
            mem_wdata_d = bus.dbg_wdata;
          end else begin
            mem_we_d    = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
          end
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == LAT_CNT) begin
          cnt_d   = '0;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: strobe, owner's ack pulse and ack-gated read data.
  always_comb begin
    ack       = (state_q == ARB_WAIT) && (cnt_q == LAT_CNT);
    cpu_ack   = ack && (owner_q == REQ_CPU);
    dbg_ack   = ack && (owner_q == REQ_DBG);
    cpu_rdata = (cpu_ack && !mem_we_q) ? bus.mem_rdata : '0;
    dbg_rdata = (dbg_ack && !mem_we_q) ? bus.mem_rdata : '0;
  end

  assign bus.cpu_ack   = cpu_ack;
  assign bus.dbg_ack   = dbg_ack;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.dbg_rdata = dbg_rdata;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
  assign bus.mem_en    = (state_q == ARB_ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // The owner must keep its request high until its ack cycle.
  logic owner_req;
  assign owner_req = (owner_q == REQ_CPU) ? bus.cpu_req : bus.dbg_req;

  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (state_q != ARB_IDLE) |-> owner_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_port_arbiter;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (bus3)
  );

  // Memory model: fixed contents, data valid only MEM_LAT cycles after mem_en.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEAD_BEEF;
      32'h14:  return 32'h1234_5678;
      32'h20:  return 32'h2020_2020;
      default: return {a[15:0], 16'hA5A5};
    endcase
  endfunction

  logic [3:0]  vp1 = '0;
  logic [3:0]  vp3 = '0;
  logic [31:0] wr_addr3 = '0;
  logic [31:0] wr_data3 = '0;
  int          wr_cnt3  = 0;

  always @(posedge clk) begin
    vp1 <= {vp1[2:0], bus1.mem_en};
    vp3 <= {vp3[2:0], bus3.mem_en};
    if (bus3.mem_en && bus3.mem_we) begin
      wr_addr3 <= bus3.mem_addr;
      wr_data3 <= bus3.mem_wdata;
      wr_cnt3  <= wr_cnt3 + 1;
    end
  end

  assign bus1.mem_rdata = vp1[0] ? data_of(bus1.mem_addr) : 32'hBAD0_BAD0;
  assign bus3.mem_rdata = vp3[2] ? data_of(bus3.mem_addr) : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_addr = '0; bus1.dbg_wdata = '0;
    bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    bus3.dbg_req = 0; bus3.dbg_we = 0; bus3.dbg_addr = '0; bus3.dbg_wdata = '0;
  endtask

  task automatic reset_dut1();
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
  endtask

  task automatic reset_dut3();
    rst3 = 1'b1;
    step();
    rst3 = 1'b0;
  endtask

  // Both instances come out of reset with every output at zero.
  task automatic test_reset();
    logic [31:0] agg1, agg3;
    idle_inputs();
    #2;
    agg1 = {26'd0, bus1.cpu_ack, bus1.dbg_ack, bus1.mem_en, bus1.mem_we, bus1.cpu_stall, 1'b0}
           | bus1.mem_addr | bus1.mem_wdata | bus1.cpu_rdata | bus1.dbg_rdata;
    agg3 = {26'd0, bus3.cpu_ack, bus3.dbg_ack, bus3.mem_en, bus3.mem_we, bus3.cpu_stall, 1'b0}
           | bus3.mem_addr | bus3.mem_wdata | bus3.cpu_rdata | bus3.dbg_rdata;
    n_total++; if (agg1 !== 32'd0) $display("FAIL reset_outputs_lat1: got %h want 0", agg1); else n_pass++;
    n_total++; if (agg3 !== 32'd0) $display("FAIL reset_outputs_lat3: got %h want 0", agg3); else n_pass++;
    step();
    rst1 = 1'b0;
    rst3 = 1'b0;
    step();
    n_total++; if (bus1.mem_en !== 1'b0) $display("FAIL idle_no_strobe: got %b want 0", bus1.mem_en); else n_pass++;
  endtask

  // Single CPU read with MEM_LAT=1.
  task automatic test_single_read();
    reset_dut1();
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 32'h10;
    #1;
    n_total++; if (bus1.cpu_stall !== 1'b1) $display("FAIL rd_stall_c0: got %b want 1", bus1.cpu_stall); else n_pass++;
    n_total++; if (bus1.mem_en !== 1'b0) $display("FAIL rd_en_c0: got %b want 0", bus1.mem_en); else n_pass++;
    step();
    n_total++; if (bus1.mem_en !== 1'b1) $display("FAIL rd_en_c1: got %b want 1", bus1.mem_en); else n_pass++;
    n_total++; if (bus1.mem_addr !== 32'h10) $display("FAIL rd_addr_c1: got %h want 10", bus1.mem_addr); else n_pass++;
    n_total++; if (bus1.mem_we !== 1'b0) $display("FAIL rd_we_c1: got %b want 0", bus1.mem_we); else n_pass++;
    n_total++; if (bus1.cpu_stall !== 1'b1) $display("FAIL rd_stall_c1: got %b want 1", bus1.cpu_stall); else n_pass++;
    n_total++; if (bus1.cpu_ack !== 1'b0) $display("FAIL rd_ack_c1: got %b want 0", bus1.cpu_ack); else n_pass++;
    step();
    n_total++; if (bus1.cpu_ack !== 1'b1) $display("FAIL rd_ack_c2: got %b want 1", bus1.cpu_ack); else n_pass++;
    n_total++; if (bus1.cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data_c2: got %h want deadbeef", bus1.cpu_rdata); else n_pass++;
    n_total++; if (bus1.cpu_stall !== 1'b0) $display("FAIL rd_stall_c2: got %b want 0", bus1.cpu_stall); else n_pass++;
    n_total++; if (bus1.mem_en !== 1'b0) $display("FAIL rd_en_c2: got %b want 0", bus1.mem_en); else n_pass++;
    step();
    bus1.cpu_req = 0;
    #1;
    n_total++; if (bus1.cpu_ack !== 1'b0) $display("FAIL rd_ack_c3: got %b want 0", bus1.cpu_ack); else n_pass++;
    n_total++; if (bus1.cpu_rdata !== 32'h0) $display("FAIL rd_data_c3: got %h want 0", bus1.cpu_rdata); else n_pass++;
  endtask

  // Both ports request continuously; one access every 3 cycles at MEM_LAT=1.
  task automatic test_contention();
    logic        exp_en, ack_cyc, dbg_owns, exp_cack, exp_dack;
    logic [31:0] exp_addr, exp_crd, exp_drd;
    reset_dut1();
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 32'h10;
    bus1.dbg_req = 1; bus1.dbg_we = 0; bus1.dbg_addr = 32'h14;
    #1;
    for (int c = 0; c < 12; c++) begin
`ifdef DBG_PRIORITY_EN
      dbg_owns = 1'b1;
`else
      dbg_owns = ((c / 3) % 2) == 1;
`endif
      exp_en   = (c % 3) == 1;
      ack_cyc  = (c % 3) == 2;
      exp_cack = ack_cyc && !dbg_owns;
      exp_dack = ack_cyc && dbg_owns;
      exp_addr = dbg_owns ? 32'h14 : 32'h10;
      exp_crd  = exp_cack ? 32'hDEAD_BEEF : 32'h0;
      exp_drd  = exp_dack ? 32'h1234_5678 : 32'h0;
      n_total++; if (bus1.mem_en !== exp_en) $display("FAIL cont_en c%0d: got %b want %b", c, bus1.mem_en, exp_en); else n_pass++;
      n_total++; if (bus1.cpu_ack !== exp_cack) $display("FAIL cont_cpu_ack c%0d: got %b want %b", c, bus1.cpu_ack, exp_cack); else n_pass++;
      n_total++; if (bus1.dbg_ack !== exp_dack) $display("FAIL cont_dbg_ack c%0d: got %b want %b", c, bus1.dbg_ack, exp_dack); else n_pass++;
      n_total++; if (bus1.cpu_stall !== !exp_cack) $display("FAIL cont_stall c%0d: got %b want %b", c, bus1.cpu_stall, !exp_cack); else n_pass++;
      n_total++; if (bus1.cpu_rdata !== exp_crd) $display("FAIL cont_cpu_rdata c%0d: got %h want %h", c, bus1.cpu_rdata, exp_crd); else n_pass++;
      n_total++; if (bus1.dbg_rdata !== exp_drd) $display("FAIL cont_dbg_rdata c%0d: got %h want %h", c, bus1.dbg_rdata, exp_drd); else n_pass++;
      if (exp_en) begin
        n_total++; if (bus1.mem_addr !== exp_addr) $display("FAIL cont_addr c%0d: got %h want %h", c, bus1.mem_addr, exp_addr); else n_pass++;
      end
      step();
    end
    bus1.cpu_req = 0;
    bus1.dbg_req = 0;
  endtask

  // Debug write with MEM_LAT=3; inputs changed after grant must not leak through.
  task automatic test_write_lat3();
    int wr_before;
    reset_dut3();
    wr_before = wr_cnt3;
    bus3.dbg_req = 1; bus3.dbg_we = 1; bus3.dbg_addr = 32'h40; bus3.dbg_wdata = 32'h0000_00FF;
    #1;
    n_total++; if (bus3.mem_en !== 1'b0) $display("FAIL wr_en_c0: got %b want 0", bus3.mem_en); else n_pass++;
    step();
    n_total++; if (bus3.mem_en !== 1'b1) $display("FAIL wr_en_c1: got %b want 1", bus3.mem_en); else n_pass++;
    n_total++; if (bus3.mem_we !== 1'b1) $display("FAIL wr_we_c1: got %b want 1", bus3.mem_we); else n_pass++;
    n_total++; if (bus3.mem_addr !== 32'h40) $display("FAIL wr_addr_c1: got %h want 40", bus3.mem_addr); else n_pass++;
    n_total++; if (bus3.mem_wdata !== 32'hFF) $display("FAIL wr_data_c1: got %h want ff", bus3.mem_wdata); else n_pass++;
    bus3.dbg_addr = 32'h44; bus3.dbg_wdata = 32'hAAAA_AAAA;
    step();
    n_total++; if (bus3.mem_en !== 1'b0) $display("FAIL wr_en_c2: got %b want 0", bus3.mem_en); else n_pass++;
    n_total++; if (bus3.mem_wdata !== 32'hFF) $display("FAIL wr_data_c2: got %h want ff", bus3.mem_wdata); else n_pass++;
    n_total++; if (bus3.dbg_ack !== 1'b0) $display("FAIL wr_ack_c2: got %b want 0", bus3.dbg_ack); else n_pass++;
    step();
    n_total++; if (bus3.dbg_ack !== 1'b0) $display("FAIL wr_ack_c3: got %b want 0", bus3.dbg_ack); else n_pass++;
    step();
    n_total++; if (bus3.dbg_ack !== 1'b1) $display("FAIL wr_ack_c4: got %b want 1", bus3.dbg_ack); else n_pass++;
    n_total++; if (bus3.dbg_rdata !== 32'h0) $display("FAIL wr_rdata_c4: got %h want 0", bus3.dbg_rdata); else n_pass++;
    n_total++; if (bus3.cpu_ack !== 1'b0) $display("FAIL wr_cpu_ack_c4: got %b want 0", bus3.cpu_ack); else n_pass++;
    step();
    bus3.dbg_req = 0; bus3.dbg_we = 0;
    #1;
    n_total++; if (bus3.dbg_ack !== 1'b0) $display("FAIL wr_ack_c5: got %b want 0", bus3.dbg_ack); else n_pass++;
    n_total++; if (wr_cnt3 !== wr_before + 1) $display("FAIL wr_count: got %0d want %0d", wr_cnt3, wr_before + 1); else n_pass++;
    n_total++; if (wr_addr3 !== 32'h40) $display("FAIL wr_mem_addr: got %h want 40", wr_addr3); else n_pass++;
    n_total++; if (wr_data3 !== 32'hFF) $display("FAIL wr_mem_data: got %h want ff", wr_data3); else n_pass++;
  endtask

  // CPU read at MEM_LAT=3 whose request fields change during the wait.
  task automatic test_addr_latch();
    reset_dut3();
    bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 32'h10;
    step();
    n_total++; if (bus3.mem_addr !== 32'h10) $display("FAIL latch_addr_c1: got %h want 10", bus3.mem_addr); else n_pass++;
    bus3.cpu_addr = 32'h20; bus3.cpu_we = 1; bus3.cpu_wdata = 32'h55;
    step();
    n_total++; if (bus3.mem_addr !== 32'h10) $display("FAIL latch_addr_c2: got %h want 10", bus3.mem_addr); else n_pass++;
    n_total++; if (bus3.mem_we !== 1'b0) $display("FAIL latch_we_c2: got %b want 0", bus3.mem_we); else n_pass++;
    step();
    n_total++; if (bus3.mem_addr !== 32'h10) $display("FAIL latch_addr_c3: got %h want 10", bus3.mem_addr); else n_pass++;
    n_total++; if (bus3.cpu_stall !== 1'b1) $display("FAIL latch_stall_c3: got %b want 1", bus3.cpu_stall); else n_pass++;
    step();
    n_total++; if (bus3.cpu_ack !== 1'b1) $display("FAIL latch_ack_c4: got %b want 1", bus3.cpu_ack); else n_pass++;
    n_total++; if (bus3.cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL latch_rdata_c4: got %h want deadbeef", bus3.cpu_rdata); else n_pass++;
    step();
    bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_wdata = '0;
  endtask

  // Reset during the wait abandons the access; a new request then completes.
  task automatic test_reset_mid();
    reset_dut3();
    bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 32'h10;
    step();
    step();
    rst3 = 1'b1;
    #1;
    n_total++; if (bus3.mem_addr !== 32'h0) $display("FAIL mid_rst_addr: got %h want 0", bus3.mem_addr); else n_pass++;
    n_total++; if (bus3.cpu_ack !== 1'b0) $display("FAIL mid_rst_ack: got %b want 0", bus3.cpu_ack); else n_pass++;
    n_total++; if (bus3.mem_en !== 1'b0) $display("FAIL mid_rst_en: got %b want 0", bus3.mem_en); else n_pass++;
    bus3.cpu_req = 0;
    step();
    rst3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_total++; if ((bus3.cpu_ack | bus3.mem_en) !== 1'b0) $display("FAIL mid_rst_quiet c%0d: got ack=%b en=%b want 0", c, bus3.cpu_ack, bus3.mem_en); else n_pass++;
      step();
    end
    bus3.cpu_req = 1; bus3.cpu_addr = 32'h14;
    step();
    n_total++; if (bus3.mem_en !== 1'b1) $display("FAIL mid_fresh_en: got %b want 1", bus3.mem_en); else n_pass++;
    step();
    step();
    step();
    n_total++; if (bus3.cpu_ack !== 1'b1) $display("FAIL mid_fresh_ack: got %b want 1", bus3.cpu_ack); else n_pass++;
    n_total++; if (bus3.cpu_rdata !== 32'h1234_5678) $display("FAIL mid_fresh_rdata: got %h want 12345678", bus3.cpu_rdata); else n_pass++;
    step();
    bus3.cpu_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_lat3();
    test_addr_latch();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
